// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH {pc, instr} entries, 1-cycle enq-to-deq latency, enq_ready independent of deq_ready.
// Optional FETCH_QUEUE_BYPASS_EN forwards enq straight to deq when empty (zero latency); flush empties the queue at the edge.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_instr,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             enq_fire;
  logic             deq_fire;
  logic             wr_en;
  logic             rd_en;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic             bypass;
`endif

  assign count = cnt;

  always_comb begin
    enq_ready = (cnt != FULL_CNT) & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = (cnt == '0) & enq_valid & ~flush;
    deq_valid = ((cnt != '0) | enq_valid) & ~flush;
    deq_pc    = bypass ? enq_pc    : mem[head].pc;
    deq_instr = bypass ? enq_instr : mem[head].instr;
`else
    deq_valid = (cnt != '0) & ~flush;
    deq_pc    = mem[head].pc;
    deq_instr = mem[head].instr;
`endif
    enq_fire = enq_valid & enq_ready;
    deq_fire = deq_valid & deq_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
    // A bypassed entry consumed this cycle never touches storage.
    wr_en = enq_fire & ~(bypass & deq_ready);
    rd_en = deq_fire & ~bypass;
`else
    wr_en = enq_fire;
    rd_en = deq_fire;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left unreset; deq data is meaningless while deq_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= {enq_pc, enq_instr};
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (cnt <= FULL_CNT);
`ifndef FETCH_QUEUE_BYPASS_EN
      assert (!(deq_valid && cnt == '0));
`endif
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, corner sequences and random traffic against a queue model.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_pc = '0;
  logic [31:0] enq_instr = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;
  logic [63:0] q [$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare against the queue model, then advance the model to the edge.
  task automatic cycle(input logic fl, input logic ev, input logic [31:0] pc,
                       input logic [31:0] ins, input logic dr);
    int n;
    logic xer, xdv, enq, deq;
    logic [63:0] xhead;
    @(negedge clk);
    flush = fl; enq_valid = ev; enq_pc = pc; enq_instr = ins; deq_ready = dr;
    #1;
    n   = q.size();
    xer = (n < DEPTH) && !fl;
    xdv = !fl && (n > 0 || (BYP && ev));
    xhead = (n > 0) ? q[0] : {pc, ins};
    chk("enq_ready", 32'(enq_ready), 32'(xer));
    chk("deq_valid", 32'(deq_valid), 32'(xdv));
    chk("count", 32'(count), 32'(n));
    if (xdv) begin
      chk("deq_pc", deq_pc, xhead[63:32]);
      chk("deq_instr", deq_instr, xhead[31:0]);
    end
    enq = ev && xer;
    deq = xdv && dr;
    if (fl) q.delete();
    else if (!(deq && n == 0)) begin
      if (deq) void'(q.pop_front());
      if (enq) q.push_back({pc, ins});
    end
  endtask

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        dr;
    logic        xdv;
    logic        xer;
    logic [2:0]  xcnt;
    logic [31:0] xpc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] pc;
    tbl[0]  = '{1'b1, 32'h6000_0000, 1'b0, BYP,  1'b1, 3'd0, 32'h6000_0000};
    tbl[1]  = '{1'b1, 32'h6000_0004, 1'b0, 1'b1, 1'b1, 3'd1, 32'h6000_0000};
    tbl[2]  = '{1'b1, 32'h6000_0008, 1'b0, 1'b1, 1'b1, 3'd2, 32'h6000_0000};
    tbl[3]  = '{1'b1, 32'h6000_000C, 1'b0, 1'b1, 1'b1, 3'd3, 32'h6000_0000};
    tbl[4]  = '{1'b1, 32'h6000_0010, 1'b0, 1'b1, 1'b0, 3'd4, 32'h6000_0000};
    tbl[5]  = '{1'b1, 32'h6000_0010, 1'b0, 1'b1, 1'b0, 3'd4, 32'h6000_0000};
    tbl[6]  = '{1'b1, 32'h6000_0010, 1'b0, 1'b1, 1'b0, 3'd4, 32'h6000_0000};
    tbl[7]  = '{1'b1, 32'h6000_0010, 1'b1, 1'b1, 1'b0, 3'd4, 32'h6000_0000};
    tbl[8]  = '{1'b1, 32'h6000_0010, 1'b1, 1'b1, 1'b1, 3'd3, 32'h6000_0004};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 3'd3, 32'h6000_0008};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 3'd2, 32'h6000_000C};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 3'd1, 32'h6000_0010};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 3'd0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Fill to full, hold a fifth, drain in order
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      flush = 1'b0; enq_valid = tbl[i].ev; enq_pc = tbl[i].pc;
      enq_instr = mk_instr(tbl[i].pc); deq_ready = tbl[i].dr;
      #1;
      chk($sformatf("tbl%0d_deq_valid", i), 32'(deq_valid), 32'(tbl[i].xdv));
      chk($sformatf("tbl%0d_enq_ready", i), 32'(enq_ready), 32'(tbl[i].xer));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].xcnt));
      if (tbl[i].xdv) begin
        chk($sformatf("tbl%0d_deq_pc", i), deq_pc, tbl[i].xpc);
        chk($sformatf("tbl%0d_deq_instr", i), deq_instr, mk_instr(tbl[i].xpc));
      end
    end

    // Simultaneous enq/deq at count 2, pointers wrap
    cycle(0, 1, 32'h7000_0000, mk_instr(32'h7000_0000), 0);
    cycle(0, 1, 32'h7000_0004, mk_instr(32'h7000_0004), 0);
    for (int i = 0; i < 10; i++) begin
      pc = 32'h7000_0008 + 32'(4 * i);
      cycle(0, 1, pc, mk_instr(pc), 1);
    end
    cycle(0, 0, 0, 0, 0);
    chk("steady_count", 32'(count), 32'd2);

    // Get to 3, then flush against a firing enq and deq
    cycle(0, 1, 32'h7100_0000, mk_instr(32'h7100_0000), 0);
    cycle(1, 1, 32'h7100_0004, mk_instr(32'h7100_0004), 1);
    cycle(0, 0, 0, 0, 1);
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_deq_valid", 32'(deq_valid), 32'd0);

    // Empty queue, addi x1,x0,5
    cycle(0, 1, 32'h7200_0000, 32'h0050_0093, 1);
    chk("addi_same_cycle_valid", 32'(deq_valid), 32'(BYP));
    cycle(0, 0, 0, 0, 1);
    chk("addi_next_cycle_valid", 32'(deq_valid), 32'(!BYP));
    if (!BYP) chk("addi_next_cycle_instr", deq_instr, 32'h0050_0093);
    cycle(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      pc = $urandom;
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), pc, $urandom,
            ($urandom_range(0, 9) < 6));
    end

    // Asynchronous reset mid-cycle with contents present
    cycle(0, 1, 32'h7300_0000, 0, 0);
    cycle(0, 1, 32'h7300_0004, 0, 0);
    @(negedge clk);
    enq_valid = 1'b0; deq_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_deq_valid", 32'(deq_valid), 32'd0);
    chk("arst_enq_ready", 32'(enq_ready), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    #1 rst = 1'b0;
    q.delete();
    cycle(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
